// File: rtl/uart_pkg.sv
// Shared UART receiver types, default constants and the even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT = 10;
    localparam int UART_DATA_BITS    = 8;

    // Returns the bit that makes the total number of ones even.
    function automatic logic uart_parity_even(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_lock_if.sv
// Receive-side byte buffer interface. Valid/ready: a byte transfers in any cycle where
// rx_valid and rx_ready are both high; rx_valid holds with stable data until that cycle.
interface uart_rx_lock_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a configurable reset value for asynchronous single-bit inputs.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_lock.sv
// UART receiver gated by PLL lock, with a single-entry output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_lock
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pll_locked,
    input  logic           uart_rxd,
    uart_rx_lock_if.master rx,
    output uart_rx_state_t state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 perr_q;
    logic                 bit_tick;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    assign bit_tick = (cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic       par_pend;
    logic [7:0] data_ext;

    always_comb begin
        data_ext                 = '0;
        data_ext[DATA_BITS-1:0]  = shift;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend <= 1'b0;
`endif
        end else begin
            ovr_q <= 1'b0;
            // A commit in the same cycle overrides this clear below.
            if (valid_q && rx.rx_ready) valid_q <= 1'b0;

            if (!pll_locked) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // The detection cycle is cycle 0, so the next cycle counts as 1.
                        if (!rxd_s) begin
                            state   <= START;
                            cnt     <= CNT_W'(1);
                            bit_idx <= '0;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt   <= '0;
                            state <= rxd_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            cnt     <= '0;
                            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (bit_tick) begin
                            cnt      <= '0;
                            par_pend <= rxd_s ^ uart_parity_even(data_ext);
                            state    <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_tick) begin
                            cnt   <= '0;
                            state <= rxd_s ? IDLE : BREAK;
                            if (!valid_q || rx.rx_ready) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                                ferr_q  <= ~rxd_s;
`ifdef UART_RX_PARITY_EN
                                perr_q  <= par_pend;
`endif
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rxd_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.parity_err = perr_q;
    assign rx.overrun    = ovr_q;
endmodule

// File: doc/uart_rx_lock.md
# uart_rx_lock

UART serial receiver that runs in the PLL-generated UART clock domain (1.171875 MHz) and consumes both the PLL output clock and its lock indication. It deserializes the asynchronous `uart_rxd` pin into bytes, checks framing, and presents each byte on a single-entry valid/ready output buffer to the board-protocol logic. The receiver stays idle until the PLL reports lock.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per UART bit; 1.171875 MHz / 115200 baud gives 1.7 % error. Minimum value is 4.
- `DATA_BITS`, default 8: payload bits per frame, sent LSB first. Allowed range is 5–8.
- `clk` input, 1 bit: UART clock from the PLL `outclk_0`.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `pll_locked` input, 1 bit: PLL `locked`. While it is low, the FSM is held in IDLE.
- `uart_rxd` input, 1 bit: raw serial line, idle high. Asynchronous to `clk`.
- `rx_data` output, `DATA_BITS` bits: received byte, zero-extended. Valid while `rx_valid` is high.
- `rx_valid` output, 1 bit: the buffer holds a byte.
- `rx_ready` input, 1 bit: consumer accepts the byte.
- `frame_err` output, 1 bit: the buffered byte had a low stop bit. Qualified by `rx_valid`.
- `parity_err` output, 1 bit: the buffered byte failed the parity check. Tied 0 when parity is compiled out.
- `overrun` output, 1 bit: one-cycle pulse when a completed byte is dropped because the buffer is full.

## Operation
- **Input synchronization:** `uart_rxd` passes through a 2-flop synchronizer to give `rxd_s`. The synchronizer flops reset to 1.
- **IDLE:** wait for `rxd_s` to go 0 while `pll_locked` is 1, then reset the bit counter and go to START.
- **START:**
  - At count `CLKS_PER_BIT/2 - 1`, sample `rxd_s`.
  - If it is 0, go to DATA with the counter restarted.
  - If it is 1, the low was a glitch: return to IDLE and deliver nothing.
- **DATA:**
  - Sample every `CLKS_PER_BIT` cycles into a shift register, LSB first.
  - After `DATA_BITS` samples, go to PARITY (if configured) or STOP.
- **PARITY:** one sample. Even parity over the data bits; a mismatch sets the pending parity error.
- **STOP:** one sample. A value of 0 sets the pending frame error.
  - The byte is then committed to the buffer.
  - Next state is IDLE if the stop sample was 1, or BREAK if it was 0.
- **BREAK:** wait for `rxd_s` to be 1, then go to IDLE. This prevents a held-low line from retriggering START.
- **Buffer commit rules:**
  - If the buffer is empty, or `rx_valid && rx_ready` in the commit cycle: load `rx_data`, `frame_err` and `parity_err`, and hold `rx_valid` at 1.
  - Otherwise the old byte is retained, the new byte is discarded, and `overrun` pulses.
  - A handshake with no commit in the same cycle clears `rx_valid`.
- **Lock loss:** `pll_locked` falling in any state forces IDLE on the next edge and aborts the partial frame with no delivery. The buffer contents and `rx_valid` are kept.
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, FSM in IDLE, counters 0.

## Timing
- Cycle 0 is the first cycle in which `rxd_s` = 0, which is 2 cycles after the pin falls.
- The start sample is at cycle `CLKS_PER_BIT/2 - 1`.
- Data bit i is sampled at `CLKS_PER_BIT/2 - 1 + (i+1)*CLKS_PER_BIT`.
- The stop bit is sampled `CLKS_PER_BIT` after the last data or parity bit.
- `rx_valid` rises on the cycle after the stop sample. With defaults, the stop sample is cycle 94 and `rx_valid` is high from cycle 95.
- The next start edge is recognized in the cycle after the stop sample. Back-to-back frames have no dead time beyond that.
- `rx_ready` is sampled combinationally with `rx_valid`. There is no combinational path from `rx_ready` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the frame is start + `DATA_BITS` + even parity + stop, and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state, the frame is 8N1, and `parity_err` is constant 0.

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default constants `UART_CLKS_PER_BIT` = 10 and `UART_DATA_BITS` = 8;
  - function `uart_parity_even`.
- **Sub-module `uart_sync2`:** 2-flop synchronizer, parameterized reset value, async active-low reset. It will be reused by the transmitter's CTS path.

## Test plan
- **Single byte:** send 0xA5 at 10 clk/bit → `rx_data` = 0xA5, `rx_valid` high at cycle 95, both error flags 0.
- **Glitch:** 3-cycle low pulse on `uart_rxd` → FSM returns to IDLE, `rx_valid` stays 0.
- **Bad stop:** 0x3C with stop bit 0, line held low for 40 cycles → `rx_data` = 0x3C with `frame_err` = 1; no second frame until the line returns high.
- **Overrun:** two back-to-back frames 0x11 and 0x22 with `rx_ready` = 0 → `rx_data` stays 0x11, `overrun` pulses once at the second commit. Repeat with `rx_ready` = 1 in the commit cycle → `rx_data` = 0x22, no overrun.
- **Lock loss:** drop `pll_locked` mid-byte, then restore it and send 0x5A → the aborted frame is not delivered; `rx_data` = 0x5A.
- **Parity (`UART_RX_PARITY_EN` defined):** 0x07 with parity bit 0 → `parity_err` = 1, `rx_valid` at cycle 105. The same byte with parity bit 1 → `parity_err` = 0.
